// File: rtl/falafel_freelist_walker.sv
// Free-list walker: follows a singly linked list of free blocks in memory and
// reports a first-fit or best-fit block for a requested payload size.
module falafel_freelist_walker #(
    parameter int DATA_W    = 32,
    parameter int WORD_SIZE = 4,
    parameter int FIT_MODE  = 0,
    parameter int MAX_HOPS  = 1024,
    parameter int NULL_PTR  = 0
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_val_i,
    output logic              req_rdy_o,
    input  logic [DATA_W-1:0] req_head_addr_i,
    input  logic [DATA_W-1:0] req_size_i,
    output logic              rsp_val_o,
    input  logic              rsp_rdy_i,
    output logic              rsp_found_o,
    output logic              rsp_err_o,
    output logic [DATA_W-1:0] rsp_block_ptr_o,
    output logic [DATA_W-1:0] rsp_prev_ptr_o,
    output logic [DATA_W-1:0] rsp_size_o,
    output logic [DATA_W-1:0] rsp_next_ptr_o,
    output logic              mem_req_val_o,
    input  logic              mem_req_rdy_i,
    output logic [DATA_W-1:0] mem_req_addr_o,
    input  logic              mem_rsp_val_i,
    output logic              mem_rsp_rdy_o,
    input  logic [DATA_W-1:0] mem_rsp_data_i
);

    localparam int HOP_W = $clog2(MAX_HOPS + 1);
    localparam logic [HOP_W-1:0]  HOP_MAX = HOP_W'(MAX_HOPS);
    localparam logic [DATA_W-1:0] STRIDE  = DATA_W'(WORD_SIZE);
    localparam logic [DATA_W-1:0] NULL_W  = DATA_W'(NULL_PTR);

    typedef enum logic [3:0] {
        IDLE, LOAD_HEAD, WAIT_HEAD, LOAD_SIZE, WAIT_SIZE,
        LOAD_NEXT, WAIT_NEXT, EVAL, RESP
    } state_t;

    state_t state, next_state;

    logic [DATA_W-1:0] req_size, cur, prev, cur_size, cur_next, mem_addr;
    logic [HOP_W-1:0]  hops;
    logic              cand_valid;
    logic [DATA_W-1:0] cand_ptr, cand_prev, cand_size, cand_next;
    logic              res_found, res_err;
    logic [DATA_W-1:0] res_ptr, res_prev, res_size, res_next;

    logic              fits, better, hit, at_end, hop_limit;
    logic              pick_valid;
    logic [DATA_W-1:0] pick_ptr, pick_prev, pick_size, pick_next;

    // Block evaluation: the "pick" is the candidate as it stands after this block.
    always_comb begin
        fits      = cur_size >= req_size;
        better    = fits && (!cand_valid || cur_size < cand_size);
        hit       = (FIT_MODE == 0) ? fits : (fits && cur_size == req_size);
        at_end    = cur_next == NULL_W;
        hop_limit = hops == HOP_MAX;
        pick_valid = cand_valid;
        pick_ptr   = cand_ptr;
        pick_prev  = cand_prev;
        pick_size  = cand_size;
        pick_next  = cand_next;
        if ((FIT_MODE == 0) ? fits : better) begin
            pick_valid = 1'b1;
            pick_ptr   = cur;
            pick_prev  = prev;
            pick_size  = cur_size;
            pick_next  = cur_next;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:      if (req_val_i) next_state = (req_size_i == '0) ? RESP : LOAD_HEAD;
            LOAD_HEAD: if (mem_req_rdy_i) next_state = WAIT_HEAD;
            WAIT_HEAD: if (mem_rsp_val_i) next_state = (mem_rsp_data_i == NULL_W) ? RESP : LOAD_SIZE;
            LOAD_SIZE: if (mem_req_rdy_i) next_state = WAIT_SIZE;
            WAIT_SIZE: if (mem_rsp_val_i) next_state = LOAD_NEXT;
            LOAD_NEXT: if (mem_req_rdy_i) next_state = WAIT_NEXT;
            WAIT_NEXT: if (mem_rsp_val_i) next_state = EVAL;
            EVAL:      next_state = (hit || at_end || hop_limit) ? RESP : LOAD_SIZE;
            RESP:      if (rsp_rdy_i) next_state = IDLE;
            default:   next_state = IDLE;
        endcase
    end

    // Result registers are cleared on acceptance so not-found responses carry zeros.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            req_size   <= '0;
            cur        <= '0;
            prev       <= '0;
            cur_size   <= '0;
            cur_next   <= '0;
            mem_addr   <= '0;
            hops       <= '0;
            cand_valid <= 1'b0;
            cand_ptr   <= '0;
            cand_prev  <= '0;
            cand_size  <= '0;
            cand_next  <= '0;
            res_found  <= 1'b0;
            res_err    <= 1'b0;
            res_ptr    <= '0;
            res_prev   <= '0;
            res_size   <= '0;
            res_next   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_val_i) begin
                        req_size   <= req_size_i;
                        prev       <= req_head_addr_i - STRIDE;
                        mem_addr   <= req_head_addr_i;
                        hops       <= '0;
                        cand_valid <= 1'b0;
                        cand_ptr   <= '0;
                        cand_prev  <= '0;
                        cand_size  <= '0;
                        cand_next  <= '0;
                        res_found  <= 1'b0;
                        res_err    <= 1'b0;
                        res_ptr    <= '0;
                        res_prev   <= '0;
                        res_size   <= '0;
                        res_next   <= '0;
                    end
                end
                WAIT_HEAD: begin
                    if (mem_rsp_val_i) begin
                        cur      <= mem_rsp_data_i;
                        mem_addr <= mem_rsp_data_i;
                    end
                end
                WAIT_SIZE: begin
                    if (mem_rsp_val_i) begin
                        cur_size <= mem_rsp_data_i;
                        mem_addr <= cur + STRIDE;
                    end
                end
                WAIT_NEXT: begin
                    if (mem_rsp_val_i) begin
                        cur_next <= mem_rsp_data_i;
                        hops     <= hops + HOP_W'(1);
                    end
                end
                EVAL: begin
                    cand_valid <= pick_valid;
                    cand_ptr   <= pick_ptr;
                    cand_prev  <= pick_prev;
                    cand_size  <= pick_size;
                    cand_next  <= pick_next;
                    if (hit || at_end) begin
                        res_found <= pick_valid;
                        res_ptr   <= pick_ptr;
                        res_prev  <= pick_prev;
                        res_size  <= pick_size;
                        res_next  <= pick_next;
                    end else if (hop_limit) begin
                        res_err <= 1'b1;
                    end else begin
                        prev     <= cur;
                        cur      <= cur_next;
                        mem_addr <= cur_next;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        req_rdy_o       = (state == IDLE) && !rst_i;
        mem_req_val_o   = state inside {LOAD_HEAD, LOAD_SIZE, LOAD_NEXT};
        mem_req_addr_o  = (state inside {LOAD_HEAD, LOAD_SIZE, LOAD_NEXT}) ? mem_addr : '0;
        mem_rsp_rdy_o   = state inside {WAIT_HEAD, WAIT_SIZE, WAIT_NEXT};
        rsp_val_o       = state == RESP;
        rsp_found_o     = (state == RESP) && res_found;
        rsp_err_o       = (state == RESP) && res_err;
        rsp_block_ptr_o = (state == RESP) ? res_ptr  : '0;
        rsp_prev_ptr_o  = (state == RESP) ? res_prev : '0;
        rsp_size_o      = (state == RESP) ? res_size : '0;
        rsp_next_ptr_o  = (state == RESP) ? res_next : '0;
    end

endmodule

// File: tb/tb_falafel_freelist_walker.sv
// Bench for falafel_freelist_walker: a first-fit and a best-fit instance share
// one sparse memory image and are checked against a list-walking reference model.
module tb_falafel_freelist_walker;

    localparam int HOPS0 = 2;
    localparam int HOPS1 = 8;

    typedef struct {
        logic        found;
        logic        err;
        logic [31:0] blk;
        logic [31:0] prev;
        logic [31:0] size;
        logic [31:0] next;
        int          reads;
    } res_t;

    logic        clk, rst;
    logic        req_val [2], req_rdy [2];
    logic [31:0] req_head [2], req_size [2];
    logic        rsp_val [2], rsp_rdy [2], rsp_found [2], rsp_err [2];
    logic [31:0] rsp_block [2], rsp_prev [2], rsp_sz [2], rsp_next [2];
    logic        mem_req_val [2], mem_req_rdy [2];
    logic [31:0] mem_req_addr [2];
    logic        mem_rsp_val [2], mem_rsp_rdy [2];
    logic [31:0] mem_rsp_data [2];

    logic [31:0] mem [logic [31:0]];
    int checks, passes;

    falafel_freelist_walker #(.DATA_W(32), .WORD_SIZE(4), .FIT_MODE(0), .MAX_HOPS(HOPS0), .NULL_PTR(0)) dut0 (
        .clk_i(clk), .rst_i(rst),
        .req_val_i(req_val[0]), .req_rdy_o(req_rdy[0]),
        .req_head_addr_i(req_head[0]), .req_size_i(req_size[0]),
        .rsp_val_o(rsp_val[0]), .rsp_rdy_i(rsp_rdy[0]),
        .rsp_found_o(rsp_found[0]), .rsp_err_o(rsp_err[0]),
        .rsp_block_ptr_o(rsp_block[0]), .rsp_prev_ptr_o(rsp_prev[0]),
        .rsp_size_o(rsp_sz[0]), .rsp_next_ptr_o(rsp_next[0]),
        .mem_req_val_o(mem_req_val[0]), .mem_req_rdy_i(mem_req_rdy[0]), .mem_req_addr_o(mem_req_addr[0]),
        .mem_rsp_val_i(mem_rsp_val[0]), .mem_rsp_rdy_o(mem_rsp_rdy[0]), .mem_rsp_data_i(mem_rsp_data[0])
    );

    falafel_freelist_walker #(.DATA_W(32), .WORD_SIZE(4), .FIT_MODE(1), .MAX_HOPS(HOPS1), .NULL_PTR(0)) dut1 (
        .clk_i(clk), .rst_i(rst),
        .req_val_i(req_val[1]), .req_rdy_o(req_rdy[1]),
        .req_head_addr_i(req_head[1]), .req_size_i(req_size[1]),
        .rsp_val_o(rsp_val[1]), .rsp_rdy_i(rsp_rdy[1]),
        .rsp_found_o(rsp_found[1]), .rsp_err_o(rsp_err[1]),
        .rsp_block_ptr_o(rsp_block[1]), .rsp_prev_ptr_o(rsp_prev[1]),
        .rsp_size_o(rsp_sz[1]), .rsp_next_ptr_o(rsp_next[1]),
        .mem_req_val_o(mem_req_val[1]), .mem_req_rdy_i(mem_req_rdy[1]), .mem_req_addr_o(mem_req_addr[1]),
        .mem_rsp_val_i(mem_rsp_val[1]), .mem_rsp_rdy_o(mem_rsp_rdy[1]), .mem_rsp_data_i(mem_rsp_data[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    function automatic logic [31:0] rd(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : 32'h0;
    endfunction

    // Reference: walk the list as the allocator rules describe it, counting reads.
    function automatic res_t model(input int mode, input int max_hops, input logic [31:0] head, input logic [31:0] size);
        res_t r;
        logic [31:0] ptr, p, s, n;
        bit have;
        r.found = 0; r.err = 0; r.blk = 0; r.prev = 0; r.size = 0; r.next = 0; r.reads = 0;
        if (size == 0) return r;
        ptr = rd(head); r.reads = 1; p = head - 32'd4;
        if (ptr == 0) return r;
        have = 0;
        for (int hops = 1; hops <= max_hops; hops++) begin
            s = rd(ptr); n = rd(ptr + 32'd4); r.reads += 2;
            if (s >= size && (mode == 0 || !have || s < r.size)) begin
                have = 1; r.blk = ptr; r.prev = p; r.size = s; r.next = n;
            end
            if (have && (mode == 0 || r.size == size)) begin r.found = 1; return r; end
            if (n == 0) begin r.found = have; return r; end
            p = ptr; ptr = n;
        end
        r.err = 1; r.found = 0; r.blk = 0; r.prev = 0; r.size = 0; r.next = 0;
        return r;
    endfunction

    task automatic build_random(input int n);
        int order [8];
        int j, t;
        logic [31:0] a;
        mem.delete();
        for (int i = 0; i < 8; i++) order[i] = i;
        for (int i = 7; i > 0; i--) begin
            j = int'($urandom_range(i, 0)); t = order[i]; order[i] = order[j]; order[j] = t;
        end
        mem[32'h100] = (n == 0) ? 32'h0 : 32'h1000 + 32'(order[0]) * 32'h40;
        for (int i = 0; i < n; i++) begin
            a = 32'h1000 + 32'(order[i]) * 32'h40;
            mem[a] = 32'($urandom_range(8, 1) * 8);
            mem[a + 32'd4] = (i == n - 1) ? 32'h0 : 32'h1000 + 32'(order[i + 1]) * 32'h40;
        end
    endtask

    // Drives one search on instance d, acting as a stalling memory and consumer;
    // viol counts handshake/stability breaches seen along the way.
    task automatic run_search(input int d, input logic [31:0] head, input logic [31:0] size, input int stall,
                              output res_t got, output int viol, output bit to);
        bit pending, req_hold, rsp_hold, done;
        logic [31:0] paddr, hold_addr;
        int cyc;
        got.found = 0; got.err = 0; got.blk = 0; got.prev = 0; got.size = 0; got.next = 0; got.reads = 0;
        viol = 0; to = 0; pending = 0; req_hold = 0; rsp_hold = 0; done = 0; paddr = 0; hold_addr = 0;
        @(negedge clk);
        req_val[d] = 1'b1; req_head[d] = head; req_size[d] = size;
        cyc = 0;
        while (req_rdy[d] !== 1'b1 && cyc < 50) begin @(negedge clk); cyc++; end
        if (req_rdy[d] !== 1'b1) begin req_val[d] = 1'b0; to = 1; return; end
        @(negedge clk);
        req_val[d] = 1'b0;
        if (size != 0 && (mem_req_val[d] !== 1'b1 || mem_req_addr[d] !== head)) viol++;
        cyc = 0;
        while (!done && cyc < 3000) begin
            if (req_hold && (mem_req_val[d] !== 1'b1 || mem_req_addr[d] !== hold_addr)) viol++;
            if (rsp_hold && (rsp_val[d] !== 1'b1 || rsp_found[d] !== got.found || rsp_err[d] !== got.err ||
                             rsp_block[d] !== got.blk || rsp_prev[d] !== got.prev ||
                             rsp_sz[d] !== got.size || rsp_next[d] !== got.next)) viol++;
            if (mem_rsp_rdy[d] !== pending) viol++;
            if (req_rdy[d] !== 1'b0) viol++;
            mem_req_rdy[d] = $urandom_range(99, 0) >= stall;
            mem_rsp_val[d] = 1'b0;
            mem_rsp_data[d] = $urandom;
            if (pending && $urandom_range(99, 0) >= stall) begin
                mem_rsp_val[d] = 1'b1; mem_rsp_data[d] = rd(paddr);
            end
            rsp_rdy[d] = $urandom_range(99, 0) >= stall;
            if (rsp_val[d] === 1'b1 && !rsp_hold) begin
                got.found = rsp_found[d]; got.err = rsp_err[d]; got.blk = rsp_block[d];
                got.prev = rsp_prev[d]; got.size = rsp_sz[d]; got.next = rsp_next[d];
            end
            req_hold = mem_req_val[d] === 1'b1 && !mem_req_rdy[d];
            hold_addr = mem_req_addr[d];
            rsp_hold = rsp_val[d] === 1'b1 && !rsp_rdy[d];
            if (mem_rsp_val[d]) pending = 0;
            if (mem_req_val[d] === 1'b1 && mem_req_rdy[d]) begin
                if (pending) viol++;
                pending = 1; paddr = mem_req_addr[d]; got.reads++;
            end
            if (rsp_val[d] === 1'b1 && rsp_rdy[d]) done = 1;
            @(negedge clk);
            cyc++;
        end
        mem_req_rdy[d] = 1'b0; mem_rsp_val[d] = 1'b0; rsp_rdy[d] = 1'b0;
        if (!done) to = 1;
        else if (req_rdy[d] !== 1'b1) viol++;
    endtask

    task automatic test_reset;
        for (int d = 0; d < 2; d++) begin
            req_val[d] = 0; req_head[d] = 0; req_size[d] = 0; rsp_rdy[d] = 0;
            mem_req_rdy[d] = 0; mem_rsp_val[d] = 0; mem_rsp_data[d] = 0;
        end
        rst = 1'b0;
        #3 rst = 1'b1;
        #1;
        for (int d = 0; d < 2; d++) begin
            checks++;
            if ({req_rdy[d], rsp_val[d], mem_req_val[d], mem_rsp_rdy[d], rsp_found[d], rsp_err[d]} !== 6'b0)
                $display("[TB] FAIL reset_flags dut%0d: got %b, expected 000000", d,
                         {req_rdy[d], rsp_val[d], mem_req_val[d], mem_rsp_rdy[d], rsp_found[d], rsp_err[d]});
            else passes++;
            checks++;
            if ((rsp_block[d] | rsp_prev[d] | rsp_sz[d] | rsp_next[d] | mem_req_addr[d]) !== 32'h0)
                $display("[TB] FAIL reset_fields dut%0d: got nonzero %h, expected 0", d,
                         rsp_block[d] | rsp_prev[d] | rsp_sz[d] | rsp_next[d] | mem_req_addr[d]);
            else passes++;
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (req_rdy[d] !== 1'b1) $display("[TB] FAIL reset_ready dut%0d: got %b, expected 1", d, req_rdy[d]);
            else passes++;
        end
    endtask

    task automatic test_first_fit;
        res_t got; int viol; bit to;
        mem.delete();
        mem[32'h100] = 32'h200;
        mem[32'h200] = 32'd16; mem[32'h204] = 32'h300;
        mem[32'h300] = 32'd64; mem[32'h304] = 32'h0;
        run_search(0, 32'h100, 32'd32, 0, got, viol, to);
        checks++;
        if (got.found !== 1'b1 || got.err !== 1'b0) $display("[TB] FAIL ff_flags: got f=%b e=%b, expected f=1 e=0", got.found, got.err);
        else passes++;
        checks++;
        if (got.blk !== 32'h300 || got.prev !== 32'h200) $display("[TB] FAIL ff_ptrs: got blk=%h prev=%h, expected 300/200", got.blk, got.prev);
        else passes++;
        checks++;
        if (got.size !== 32'd64 || got.next !== 32'h0) $display("[TB] FAIL ff_words: got size=%0d next=%h, expected 64/0", got.size, got.next);
        else passes++;
        checks++;
        if (got.reads != 5 || viol != 0 || to) $display("[TB] FAIL ff_traffic: got reads=%0d viol=%0d to=%0b, expected 5/0/0", got.reads, viol, to);
        else passes++;
        run_search(0, 32'h100, 32'd8, 30, got, viol, to);
        checks++;
        if (got.found !== 1'b1 || got.blk !== 32'h200 || got.prev !== 32'h0FC || got.reads != 3 || viol != 0 || to)
            $display("[TB] FAIL ff_first_block: got f=%b blk=%h prev=%h reads=%0d viol=%0d, expected 1/200/fc/3/0",
                     got.found, got.blk, got.prev, got.reads, viol);
        else passes++;
    endtask

    task automatic test_best_fit;
        res_t got; int viol; bit to;
        logic [31:0] sz [3];
        logic [31:0] eblk [3];
        logic [31:0] eprev [3];
        int ereads [3];
        mem.delete();
        mem[32'h100] = 32'h200;
        mem[32'h200] = 32'd64; mem[32'h204] = 32'h300;
        mem[32'h300] = 32'd40; mem[32'h304] = 32'h400;
        mem[32'h400] = 32'd48; mem[32'h404] = 32'h500;
        mem[32'h500] = 32'd48; mem[32'h504] = 32'h0;
        sz[0] = 32'd32; eblk[0] = 32'h300; eprev[0] = 32'h200; ereads[0] = 9;
        sz[1] = 32'd48; eblk[1] = 32'h400; eprev[1] = 32'h300; ereads[1] = 7;
        sz[2] = 32'd41; eblk[2] = 32'h400; eprev[2] = 32'h300; ereads[2] = 9;
        for (int i = 0; i < 3; i++) begin
            run_search(1, 32'h100, sz[i], 20, got, viol, to);
            checks++;
            if (got.found !== 1'b1 || got.blk !== eblk[i] || got.prev !== eprev[i] || got.size !== rd(eblk[i]))
                $display("[TB] FAIL bf_block size=%0d: got f=%b blk=%h prev=%h sz=%0d, expected 1/%h/%h/%0d",
                         sz[i], got.found, got.blk, got.prev, got.size, eblk[i], eprev[i], rd(eblk[i]));
            else passes++;
            checks++;
            if (got.reads != ereads[i] || viol != 0 || to)
                $display("[TB] FAIL bf_traffic size=%0d: got reads=%0d viol=%0d to=%0b, expected %0d/0/0",
                         sz[i], got.reads, viol, to, ereads[i]);
            else passes++;
        end
    endtask

    task automatic test_empty_and_zero;
        res_t got; int viol; bit to;
        mem.delete();
        mem[32'h100] = 32'h0;
        run_search(1, 32'h100, 32'd16, 10, got, viol, to);
        checks++;
        if (got.found !== 1'b0 || got.err !== 1'b0 || got.blk !== 32'h0 || got.reads != 1 || viol != 0 || to)
            $display("[TB] FAIL empty_list: got f=%b e=%b blk=%h reads=%0d viol=%0d, expected 0/0/0/1/0",
                     got.found, got.err, got.blk, got.reads, viol);
        else passes++;
        mem[32'h100] = 32'h200; mem[32'h200] = 32'd64; mem[32'h204] = 32'h0;
        run_search(0, 32'h100, 32'd0, 10, got, viol, to);
        checks++;
        if (got.found !== 1'b0 || got.err !== 1'b0 || got.reads != 0 || viol != 0 || to)
            $display("[TB] FAIL zero_size: got f=%b e=%b reads=%0d viol=%0d, expected 0/0/0/0",
                     got.found, got.err, got.reads, viol);
        else passes++;
    endtask

    task automatic test_max_hops;
        res_t got; int viol; bit to;
        mem.delete();
        mem[32'h100] = 32'h200;
        mem[32'h200] = 32'd8; mem[32'h204] = 32'h300;
        mem[32'h300] = 32'd8; mem[32'h304] = 32'h400;
        mem[32'h400] = 32'd8; mem[32'h404] = 32'h0;
        run_search(0, 32'h100, 32'd32, 25, got, viol, to);
        checks++;
        if (got.err !== 1'b1 || got.found !== 1'b0 || got.blk !== 32'h0 || got.reads != 5 || viol != 0 || to)
            $display("[TB] FAIL max_hops: got e=%b f=%b blk=%h reads=%0d viol=%0d, expected 1/0/0/5/0",
                     got.err, got.found, got.blk, got.reads, viol);
        else passes++;
    endtask

    task automatic test_reset_mid_search;
        res_t got, exp; int viol; bit to;
        int bad;
        mem.delete();
        mem[32'h100] = 32'h200;
        mem[32'h200] = 32'd16; mem[32'h204] = 32'h300;
        mem[32'h300] = 32'd64; mem[32'h304] = 32'h0;
        @(negedge clk);
        req_val[0] = 1'b1; req_head[0] = 32'h100; req_size[0] = 32'd32;
        @(negedge clk);
        req_val[0] = 1'b0; mem_req_rdy[0] = 1'b1;
        @(negedge clk);
        mem_req_rdy[0] = 1'b0; mem_rsp_val[0] = 1'b1; mem_rsp_data[0] = 32'h200;
        @(negedge clk);
        mem_rsp_val[0] = 1'b0; mem_req_rdy[0] = 1'b1;
        @(negedge clk);
        mem_req_rdy[0] = 1'b0;
        checks++;
        if (mem_rsp_rdy[0] !== 1'b1 || mem_req_val[0] !== 1'b0)
            $display("[TB] FAIL mid_wait_size: got rsp_rdy=%b req_val=%b, expected 1/0", mem_rsp_rdy[0], mem_req_val[0]);
        else passes++;
        rst = 1'b1;
        #1;
        checks++;
        if ({rsp_val[0], mem_req_val[0], mem_rsp_rdy[0], req_rdy[0]} !== 4'b0)
            $display("[TB] FAIL mid_reset_outputs: got %b, expected 0000", {rsp_val[0], mem_req_val[0], mem_rsp_rdy[0], req_rdy[0]});
        else passes++;
        mem_rsp_val[0] = 1'b1; mem_rsp_data[0] = 32'd16;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (req_rdy[0] !== 1'b1) $display("[TB] FAIL mid_ready_after: got %b, expected 1", req_rdy[0]);
        else passes++;
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            if (rsp_val[0] !== 1'b0 || mem_req_val[0] !== 1'b0 || mem_rsp_rdy[0] !== 1'b0 || req_rdy[0] !== 1'b1) bad++;
            @(negedge clk);
        end
        mem_rsp_val[0] = 1'b0;
        checks++;
        if (bad != 0) $display("[TB] FAIL mid_quiet: got %0d bad cycles, expected 0", bad);
        else passes++;
        exp = model(0, HOPS0, 32'h100, 32'd32);
        run_search(0, 32'h100, 32'd32, 15, got, viol, to);
        checks++;
        if (got.found !== exp.found || got.blk !== exp.blk || got.prev !== exp.prev || got.reads != exp.reads || viol != 0 || to)
            $display("[TB] FAIL mid_next_search: got f=%b blk=%h prev=%h reads=%0d viol=%0d, expected %b/%h/%h/%0d/0",
                     got.found, got.blk, got.prev, got.reads, viol, exp.found, exp.blk, exp.prev, exp.reads);
        else passes++;
    endtask

    task automatic test_random;
        res_t got, exp; int viol; bit to;
        int d, n, stall;
        logic [31:0] size;
        for (int it = 0; it < 40; it++) begin
            d = it % 2;
            n = int'($urandom_range(5, 0));
            build_random(n);
            size = 32'($urandom_range(9, 0) * 8);
            stall = int'($urandom_range(60, 0));
            exp = model(d, (d == 0) ? HOPS0 : HOPS1, 32'h100, size);
            run_search(d, 32'h100, size, stall, got, viol, to);
            checks++;
            if (got.found !== exp.found || got.err !== exp.err || got.blk !== exp.blk || got.prev !== exp.prev ||
                got.size !== exp.size || got.next !== exp.next || got.reads != exp.reads)
                $display("[TB] FAIL random[%0d] dut%0d: got f=%b e=%b blk=%h prev=%h sz=%0d nx=%h rd=%0d, expected f=%b e=%b blk=%h prev=%h sz=%0d nx=%h rd=%0d",
                         it, d, got.found, got.err, got.blk, got.prev, got.size, got.next, got.reads,
                         exp.found, exp.err, exp.blk, exp.prev, exp.size, exp.next, exp.reads);
            else passes++;
            checks++;
            if (viol != 0 || to) $display("[TB] FAIL random_handshake[%0d] dut%0d: got viol=%0d to=%0b, expected 0/0", it, d, viol, to);
            else passes++;
        end
    endtask

    initial begin
        checks = 0;
        passes = 0;
        test_reset();
        test_first_fit();
        test_best_fit();
        test_empty_and_zero();
        test_max_hops();
        test_reset_mid_search();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
